// File: rtl/proposal_sram_writer_if.sv
// proposal_sram_writer_if: byte stream in, byte-masked SRAM write port out
interface proposal_sram_writer_if #(
  parameter int ADDR_SPACE = 4,
  parameter int Q = 16,
  parameter int BW = 8
);
  logic in_valid;
  logic in_ready;
  logic [ADDR_SPACE+3:0] in_addr;
  logic [BW-1:0] in_data;
  logic in_last;
  logic flush;
  logic sram_wsb;
  logic [ADDR_SPACE-1:0] sram_waddr;
  logic [BW*Q-1:0] sram_wdata;
  logic [Q-1:0] sram_bytemask;
  logic idle;
  modport master (
    output in_valid, in_addr, in_data, in_last, flush,
    input in_ready, sram_wsb, sram_waddr, sram_wdata, sram_bytemask, idle
  );
  modport slave (
    input in_valid, in_addr, in_data, in_last, flush,
    output in_ready, sram_wsb, sram_waddr, sram_wdata, sram_bytemask, idle
  );
endinterface

// File: rtl/proposal_sram_writer.sv
// proposal_sram_writer: coalesces addressed bytes into one byte-masked SRAM write per word visit
module proposal_sram_writer #(
  parameter int ADDR_SPACE = 4,
  parameter int Q = 16,
  parameter int BW = 8
) (
  input logic clk,
  input logic rst,
  proposal_sram_writer_if.slave bus
);
  typedef enum logic {EMPTY, FILL} state_t;
  state_t state_q, state_d;
  logic pend_q, pend_d;
  logic [ADDR_SPACE-1:0] buf_word_q, buf_word_d, c_word, w;
  logic [BW*Q-1:0] buf_data_q, buf_data_d, c_data, byte_data, lane_bits, merged_data;
  logic [Q-1:0] buf_en_q, buf_en_d, c_en, lane_en, merged_en;
  logic [3:0] b;
  logic acc, commit;
  logic wsb_q, wsb_d;
  logic [ADDR_SPACE-1:0] waddr_q, waddr_d;
  logic [BW*Q-1:0] wdata_q, wdata_d;
  logic [Q-1:0] bmask_q, bmask_d;
  assign acc = bus.in_valid & ~rst;
  assign bus.in_ready = ~rst;
  assign bus.sram_wsb = wsb_q;
  assign bus.sram_waddr = waddr_q;
  assign bus.sram_wdata = wdata_q;
  assign bus.sram_bytemask = bmask_q;
  assign bus.idle = (state_q == EMPTY) & wsb_q;
  always_comb begin
    w = bus.in_addr[ADDR_SPACE+3:4];
    b = bus.in_addr[3:0];
    byte_data = (BW*Q)'(bus.in_data) << (BW * int'(b));
    lane_bits = (BW*Q)'({BW{1'b1}}) << (BW * int'(b));
    lane_en = Q'(1) << b;
    merged_data = (buf_data_q & ~lane_bits) | byte_data;
    merged_en = buf_en_q | lane_en;
    state_d = state_q;
    pend_d = 1'b0;
    buf_word_d = buf_word_q;
    buf_data_d = buf_data_q;
    buf_en_d = buf_en_q;
    commit = 1'b0;
    c_word = buf_word_q;
    c_data = buf_data_q;
    c_en = buf_en_q;
    if (pend_q || state_q == EMPTY) begin
      commit = pend_q;
      state_d = EMPTY;
      if (acc) begin
        buf_word_d = w;
        buf_data_d = byte_data;
        buf_en_d = lane_en;
        if (bus.in_last && !pend_q) begin
          commit = 1'b1;
          c_word = w;
          c_data = byte_data;
          c_en = lane_en;
        end else begin
          state_d = FILL;
          pend_d = bus.in_last;
        end
      end
    end else if (acc && w == buf_word_q) begin
      buf_data_d = merged_data;
      buf_en_d = merged_en;
      if (&merged_en || bus.in_last) begin
        commit = 1'b1;
        c_data = merged_data;
        c_en = merged_en;
        state_d = EMPTY;
      end
    end else if (acc) begin
      commit = 1'b1;
      buf_word_d = w;
      buf_data_d = byte_data;
      buf_en_d = lane_en;
      pend_d = bus.in_last;
    end else if (bus.flush) begin
      commit = 1'b1;
      state_d = EMPTY;
    end
    wsb_d = ~commit;
    waddr_d = commit ? c_word : waddr_q;
    wdata_d = commit ? c_data : wdata_q;
    bmask_d = commit ? ~c_en : bmask_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      pend_q <= 1'b0;
      buf_word_q <= '0;
      buf_data_q <= '0;
      buf_en_q <= '0;
      wsb_q <= 1'b1;
      waddr_q <= '0;
      wdata_q <= '0;
      bmask_q <= '1;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      buf_word_q <= buf_word_d;
      buf_data_q <= buf_data_d;
      buf_en_q <= buf_en_d;
      wsb_q <= wsb_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      bmask_q <= bmask_d;
    end
  end
endmodule

// File: tb/tb_proposal_sram_writer.sv
// tb_proposal_sram_writer: directed checks of coalescing, ordering, flush and reset
module tb_proposal_sram_writer;
  logic clk, rst;
  int checks, errors;
  logic [127:0] mem [16];
  proposal_sram_writer_if bus ();
  proposal_sram_writer dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= {16{8'hE0 | 8'(i)}};
    end else if (!bus.sram_wsb) begin
      for (int k = 0; k < 16; k++)
        if (!bus.sram_bytemask[k]) mem[bus.sram_waddr][8*k +: 8] <= bus.sram_wdata[8*k +: 8];
    end
  end
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] a, input logic [7:0] d, input logic l);
    bus.in_valid = 1'b1;
    bus.in_addr = a;
    bus.in_data = d;
    bus.in_last = l;
    cyc();
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask
  task automatic do_flush();
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
  endtask
  task automatic chk_write(input string tag, input logic [3:0] a, input logic [15:0] m, input logic [127:0] d);
    chk({tag, "_wsb"}, 128'(bus.sram_wsb), 128'(0));
    chk({tag, "_waddr"}, 128'(bus.sram_waddr), 128'(a));
    chk({tag, "_mask"}, 128'(bus.sram_bytemask), 128'(m));
    chk({tag, "_data"}, bus.sram_wdata, d);
  endtask
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_addr = '0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.flush = 1'b0;
    cyc();
    cyc();
    chk("rst_ready", 128'(bus.in_ready), 128'(0));
    chk("rst_wsb", 128'(bus.sram_wsb), 128'(1));
    chk("rst_waddr", 128'(bus.sram_waddr), 128'(0));
    chk("rst_wdata", bus.sram_wdata, 128'(0));
    chk("rst_mask", 128'(bus.sram_bytemask), 128'hFFFF);
    chk("rst_idle", 128'(bus.idle), 128'(1));
    rst = 1'b0;
    #1;
    chk("ready", 128'(bus.in_ready), 128'(1));
    do_flush();
    chk("flush_empty_wsb", 128'(bus.sram_wsb), 128'(1));
    chk("flush_empty_idle", 128'(bus.idle), 128'(1));
    send(8'h3A, 8'h5C, 1'b1);
    chk_write("single", 4'h3, 16'hFBFF, 128'h0000_0000_005C_0000_0000_0000_0000_0000);
    cyc();
    chk("single_after_wsb", 128'(bus.sram_wsb), 128'(1));
    chk("single_idle", 128'(bus.idle), 128'(1));
    cyc();
    chk("single_readback", mem[3], 128'hE3E3E3E3E35CE3E3E3E3E3E3E3E3E3E3);
    for (int i = 0; i < 16; i++) begin
      send(8'h70 | 8'(i), 8'(i), 1'b0);
      if (i < 15) chk("full_nowrite", 128'(bus.sram_wsb), 128'(1));
    end
    chk_write("full", 4'h7, 16'h0000, 128'h0F0E0D0C0B0A09080706050403020100);
    cyc();
    chk("full_once", 128'(bus.sram_wsb), 128'(1));
    chk("full_idle", 128'(bus.idle), 128'(1));
    send(8'h21, 8'hA1, 1'b0);
    send(8'h25, 8'hA5, 1'b0);
    chk("switch_nowrite", 128'(bus.sram_wsb), 128'(1));
    send(8'h40, 8'hC4, 1'b0);
    chk_write("switch_w2", 4'h2, 16'hFFDD, 128'h0000_0000_0000_0000_0000_A500_0000_A100);
    cyc();
    chk("switch_pending_wsb", 128'(bus.sram_wsb), 128'(1));
    chk("switch_pending_idle", 128'(bus.idle), 128'(0));
    do_flush();
    chk_write("switch_w4", 4'h4, 16'hFFFE, 128'hC4);
    cyc();
    chk("switch_idle", 128'(bus.idle), 128'(1));
    send(8'h11, 8'hAA, 1'b0);
    send(8'h11, 8'hBB, 1'b0);
    chk("dup_nowrite", 128'(bus.sram_wsb), 128'(1));
    do_flush();
    chk_write("dup", 4'h1, 16'hFFFD, 128'hBB00);
    cyc();
    chk("dup_once", 128'(bus.sram_wsb), 128'(1));
    send(8'h21, 8'h01, 1'b0);
    send(8'h35, 8'h02, 1'b1);
    chk_write("order_w2", 4'h2, 16'hFFFD, 128'h0100);
    send(8'h36, 8'h03, 1'b1);
    chk_write("order_w3a", 4'h3, 16'hFFDF, 128'h0000_0000_0000_0000_0000_0200_0000_0000);
    cyc();
    chk_write("order_w3b", 4'h3, 16'hFFBF, 128'h0000_0000_0000_0000_0003_0000_0000_0000);
    cyc();
    chk("order_done_wsb", 128'(bus.sram_wsb), 128'(1));
    chk("order_done_idle", 128'(bus.idle), 128'(1));
    do_flush();
    chk("flush_after_wsb", 128'(bus.sram_wsb), 128'(1));
    chk("flush_after_idle", 128'(bus.idle), 128'(1));
    for (int i = 0; i < 5; i++) send(8'h90 | 8'(i), 8'h10 + 8'(i), 1'b0);
    rst = 1'b1;
    cyc();
    chk("midrst_ready", 128'(bus.in_ready), 128'(0));
    chk("midrst_wsb", 128'(bus.sram_wsb), 128'(1));
    chk("midrst_mask", 128'(bus.sram_bytemask), 128'hFFFF);
    chk("midrst_waddr", 128'(bus.sram_waddr), 128'(0));
    chk("midrst_idle", 128'(bus.idle), 128'(1));
    rst = 1'b0;
    do_flush();
    chk("midrst_flush_wsb", 128'(bus.sram_wsb), 128'(1));
    cyc();
    chk("midrst_word9", mem[9], {16{8'hE9}});
    chk("midrst_idle_end", 128'(bus.idle), 128'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
